// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the memory loader.
// State encoding, default counter width and checksum width.
package mem_loader_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_VERIFY = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  localparam int CNT_W_DEF = 16;
  localparam int CSUM_W    = 32;

endpackage

// File: rtl/mem_loader_xor_accum.sv
// XOR checksum register with synchronous clear and accumulate.
// Clear takes priority over accumulate.
module xor_accum
  import mem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [CSUM_W-1:0] din,
  output logic [CSUM_W-1:0] acc
);

  logic [CSUM_W-1:0] acc_d;
  logic [CSUM_W-1:0] acc_q;

  // next checksum value
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q ^ din;
    end
  end

  // checksum register
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/mem_loader.sv
// Streams words into memory at base+index with zero-latency writes.
// Optional read-back checksum check when MEM_LOADER_VERIFY_EN is defined.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] word_count,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic             busy,
  output logic             done,
  output logic             verify_err
);

  state_e           state_d, state_q;
  logic [31:0]      base_d, base_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [CNT_W-1:0] idx_d, idx_q;
  logic [31:0]      addr_d, addr_q;
  logic [31:0]      wdata_d, wdata_q;
  logic             err_d, err_q;
  logic             last;
  logic [31:0]      cur_addr;
  logic             wr_clr, wr_en;
  logic             rd_clr, rd_en;
  logic [31:0]      wr_sum, rd_sum;

  assign last     = (idx_q == cnt_q - CNT_W'(1));
  assign cur_addr = base_q + 32'(idx_q);

`ifdef MEM_LOADER_VERIFY_EN
  xor_accum u_wr_sum (
    .clk   (clk),
    .reset (reset),
    .clr   (wr_clr),
    .en    (wr_en),
    .din   (in_data),
    .acc   (wr_sum)
  );

  xor_accum u_rd_sum (
    .clk   (clk),
    .reset (reset),
    .clr   (rd_clr),
    .en    (rd_en),
    .din   (mem_rdata),
    .acc   (rd_sum)
  );
`else
  logic unused_sum;
  assign wr_sum     = '0;
  assign rd_sum     = '0;
  assign unused_sum = ^{wr_clr, wr_en, rd_clr, rd_en, mem_rdata};
`endif

  // next-state, datapath updates and memory-port drive
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    wr_clr    = 1'b0;
    wr_en     = 1'b0;
    rd_clr    = 1'b0;
    rd_en     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = base_addr;
          cnt_d   = word_count;
          idx_d   = '0;
          wr_clr  = 1'b1;
          rd_clr  = 1'b1;
          err_d   = 1'b0;
          state_d = (word_count == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mem_we    = 1'b1;
          mem_addr  = cur_addr;
          mem_wdata = in_data;
          addr_d    = cur_addr;
          wdata_d   = in_data;
          wr_en     = 1'b1;
          idx_d     = idx_q + CNT_W'(1);
          if (last) begin
            idx_d = '0;
`ifdef MEM_LOADER_VERIFY_EN
            state_d = S_VERIFY;
`else
            state_d = S_DONE;
`endif
          end
        end
      end
      S_VERIFY: begin
        mem_addr = cur_addr;
        addr_d   = cur_addr;
        rd_en    = 1'b1;
        idx_d    = idx_q + CNT_W'(1);
        if (last) begin
          err_d   = ((rd_sum ^ mem_rdata) != wr_sum);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
    endcase
    // reset blocks any write in the cycle it is asserted
    if (reset) begin
      in_ready = 1'b0;
      mem_we   = 1'b0;
    end
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign busy = (state_q == S_LOAD) || (state_q == S_VERIFY);
  assign done = (state_q == S_DONE);

`ifdef MEM_LOADER_VERIFY_EN
  assign verify_err = err_q;
`else
  assign verify_err = 1'b0;
`endif

endmodule
